// File: rtl/wb_dual_master_arbiter.sv
// wb_dual_master_arbiter
// Two-master, one-slave Wishbone arbiter placed in front of rapcore_caravel.
//   m0 : Caravel management SoC
//   m1 : logic-analyzer bridged bring-up master
// Round-robin arbitration. The grant is held for a whole bus cycle (while the
// owner keeps cyc high). Every hand-over passes through one IDLE cycle.
//
// Optional feature, macro WB_ARB_TIMEOUT_EN:
//   defined   - a stall counter aborts a strobe that goes unacknowledged for
//               TIMEOUT_CYCLES cycles. The owner gets a one-cycle err pulse.
//   undefined - no counter is built, m*_err_o are tied low, and a hung slave
//               keeps the grant.
module wb_dual_master_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rstn_i,
   // master 0
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic            m0_we_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   output logic [DW-1:0]   m0_dat_o,
   // master 1
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic            m1_we_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic [DW-1:0]   m1_dat_o,
   // slave
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic            s_ack_i,
   input  logic [DW-1:0]   s_dat_i,
   // current owner, one-hot
   output logic [1:0]      grant_o
);

   localparam int SW = DW / 8;

   // The state encoding is the one-hot grant itself, so grant_o can never
   // disagree with the FSM.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] OWN0 = 2'b01;
   localparam logic [1:0] OWN1 = 2'b10;

   generate
      if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
         $error("wb_dual_master_arbiter: TIMEOUT_CYCLES must be in 2..65535");
      end
   endgenerate

   // Request fields of one master, bundled so the slave-side mux is one line.
   typedef struct packed {
      logic          cyc;
      logic          stb;
      logic          we;
      logic [SW-1:0] sel;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
   } wb_req_t;

   wb_req_t    req0_bus;
   wb_req_t    req1_bus;
   wb_req_t    own_bus;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       last_owner;      // 0 = m0 held the bus last, 1 = m1
   logic       last_owner_nxt;
   logic       req0;
   logic       req1;
   logic       timeout_hit;     // current strobe is being aborted this cycle

   assign req0_bus = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                       sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i};
   assign req1_bus = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                       sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i};

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] stall_cnt;

   // Abort fires on the last stalled cycle; an ack arriving in that same
   // cycle takes precedence.
   assign timeout_hit = (state != IDLE) && !s_ack_i &&
                        (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Count consecutive unacknowledged strobe cycles of the current owner.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         stall_cnt <= '0;
      end else if (s_ack_i || (state_nxt != state)) begin
         stall_cnt <= '0;
      end else if ((state != IDLE) && own_bus.stb) begin
         stall_cnt <= stall_cnt + TW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next owner: round-robin on ties, locked while the owner holds cyc.
   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
      case (state)
         IDLE: begin
            if (req0 && req1) begin
               state_nxt = last_owner ? OWN0 : OWN1;
            end else if (req0) begin
               state_nxt = OWN0;
            end else if (req1) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            if (!m0_cyc_i || timeout_hit) begin
               state_nxt      = IDLE;
               last_owner_nxt = 1'b0;
            end
         end
         OWN1: begin
            if (!m1_cyc_i || timeout_hit) begin
               state_nxt      = IDLE;
               last_owner_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Owner and fairness history registers.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rstn_i) begin
         state      <= IDLE;
         last_owner <= 1'b1;   // m0 wins the first tie after reset
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
      end
   end

   // Select the owner's request; IDLE presents an all-zero bus.
   always_comb begin
      own_bus = '0;
      case (state)
         OWN0:    own_bus = req0_bus;
         OWN1:    own_bus = req1_bus;
         default: own_bus = '0;
      endcase
   end

   // Slave side follows the owner; an aborting strobe is withdrawn at once.
   always_comb begin
      s_cyc_o = own_bus.cyc & ~timeout_hit;
      s_stb_o = own_bus.stb & ~timeout_hit;
      s_we_o  = own_bus.we;
      s_sel_o = own_bus.sel;
      s_adr_o = own_bus.adr;
      s_dat_o = own_bus.dat;
   end

   // Master side: only the owner sees responses, stray acks in IDLE are dropped.
   always_comb begin
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_dat_o = '0;
      if (state == OWN0) begin
         m0_ack_o = s_ack_i & m0_stb_i;
         m0_err_o = timeout_hit;
         m0_dat_o = s_dat_i;
      end else if (state == OWN1) begin
         m1_ack_o = s_ack_i & m1_stb_i;
         m1_err_o = timeout_hit;
         m1_dat_o = s_dat_i;
      end
   end

   assign grant_o = state;

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Bench for wb_dual_master_arbiter: directed cycle table, hand-written
// multi-cycle sequences, then random traffic against an ownership model.
module tb_wb_dual_master_arbiter;

   localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        wb_clk_i = 1'b0;
   logic        rstn;
   logic [1:0]  cyc, stb, we;
   logic [3:0]  sel  [2];
   logic [31:0] adr  [2];
   logic [31:0] wdat [2];
   logic        s_ack;
   logic [31:0] s_dat;

   logic [1:0]  ack, err;
   logic [31:0] rdat [2];
   logic        s_cyc, s_stb, s_we;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_wdat;
   logic [1:0]  grant;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_dual_master_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
      .wb_clk_i (wb_clk_i), .wb_rstn_i(rstn),
      .m0_cyc_i (cyc[0]),   .m0_stb_i (stb[0]),  .m0_we_i (we[0]),
      .m0_sel_i (sel[0]),   .m0_adr_i (adr[0]),  .m0_dat_i(wdat[0]),
      .m0_ack_o (ack[0]),   .m0_err_o (err[0]),  .m0_dat_o(rdat[0]),
      .m1_cyc_i (cyc[1]),   .m1_stb_i (stb[1]),  .m1_we_i (we[1]),
      .m1_sel_i (sel[1]),   .m1_adr_i (adr[1]),  .m1_dat_i(wdat[1]),
      .m1_ack_o (ack[1]),   .m1_err_o (err[1]),  .m1_dat_o(rdat[1]),
      .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),   .s_we_o  (s_we),
      .s_sel_o  (s_sel),    .s_adr_o  (s_adr),   .s_dat_o (s_wdat),
      .s_ack_i  (s_ack),    .s_dat_i  (s_dat),
      .grant_o  (grant)
   );

   // ---------------- reference model: who owns the bus ----------------
   int own   = -1;   // -1 nobody, else master index
   int last  = 1;
   int stall = 0;    // consecutive unanswered strobe cycles of the owner

   function automatic bit tmo_now();
      return TMO_EN && (own >= 0) && (stall == TO - 1) && !s_ack;
   endfunction

   // Advance the model by one rising edge using the inputs just sampled.
   function automatic void mdl_edge();
      int nxt;
      bit r0, r1;
      if (!rstn) begin
         own = -1; last = 1; stall = 0;
         return;
      end
      r0  = cyc[0] && stb[0];
      r1  = cyc[1] && stb[1];
      nxt = own;
      if (own < 0) begin
         if (r0 && r1)  nxt = 1 - last;
         else if (r0)   nxt = 0;
         else if (r1)   nxt = 1;
      end else if (!cyc[own] || tmo_now()) begin
         last = own;
         nxt  = -1;
      end
      if (nxt != own || s_ack)         stall = 0;
      else if (own >= 0 && stb[own])  stall++;
      own = nxt;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Rising edge, model update, then move 1 time unit past the edge.
   task automatic step();
      @(posedge wb_clk_i);
      mdl_edge();
      #1;
   endtask

   task automatic idle_inputs();
      cyc = 2'b00; stb = 2'b00; we = 2'b00; s_ack = 1'b0;
   endtask

   // Compare every output against the model for the current cycle.
   task automatic mdl_check();
      bit          o, to;
      int          oi;
      logic [1:0]  eg;
      o  = (own >= 0);
      oi = o ? own : 0;
      to = tmo_now();
      eg = !o ? 2'b00 : (own == 0 ? 2'b01 : 2'b10);
      chk("rnd grant", grant, eg);
      chk("rnd s_cyc", s_cyc, o && cyc[oi] && !to);
      chk("rnd s_stb", s_stb, o && stb[oi] && !to);
      chk("rnd s_we",  s_we,  o && we[oi]);
      chk("rnd s_sel", s_sel, o ? sel[oi]  : 4'h0);
      chk("rnd s_adr", s_adr, o ? adr[oi]  : 32'h0);
      chk("rnd s_dat", s_wdat, o ? wdat[oi] : 32'h0);
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("rnd m%0d_ack", m), ack[m], (own == m) && s_ack && stb[m]);
         chk($sformatf("rnd m%0d_err", m), err[m], (own == m) && to);
         chk($sformatf("rnd m%0d_dat", m), rdat[m], (own == m) ? s_dat : 32'h0);
      end
   endtask

   // ---------------- directed cycle table ----------------
   typedef struct {
      bit       rst_n;
      bit       c0, s0, c1, s1, sack;
      bit [1:0] g;
      bit       scyc, sstb, a0, a1;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r, bit c0, bit s0, bit c1, bit s1, bit sa,
                               bit [1:0] g, bit sc, bit ss, bit a0, bit a1);
      vec_t v;
      v.rst_n = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.sack = sa;
      v.g = g; v.scyc = sc; v.sstb = ss; v.a0 = a0; v.a1 = a1;
      return v;
   endfunction

   initial begin
      // reset held with m0 requesting, then released: grant one cycle later
      tbl.push_back(mk(0, 1,1, 0,0, 0, 2'b00, 0,0, 0,0));
      tbl.push_back(mk(0, 1,1, 0,0, 0, 2'b00, 0,0, 0,0));
      tbl.push_back(mk(0, 1,1, 0,0, 0, 2'b00, 0,0, 0,0));
      tbl.push_back(mk(1, 1,1, 0,0, 0, 2'b00, 0,0, 0,0));
      tbl.push_back(mk(1, 1,1, 0,0, 0, 2'b01, 1,1, 0,0));
      tbl.push_back(mk(1, 1,1, 0,0, 1, 2'b01, 1,1, 1,0));
      tbl.push_back(mk(1, 0,0, 0,0, 0, 2'b01, 0,0, 0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 0, 2'b00, 0,0, 0,0));
      // fresh reset, then a tie: m0 first, one IDLE gap, then m1
      tbl.push_back(mk(0, 0,0, 0,0, 0, 2'b00, 0,0, 0,0));
      tbl.push_back(mk(1, 1,1, 1,1, 0, 2'b00, 0,0, 0,0));
      tbl.push_back(mk(1, 1,1, 1,1, 0, 2'b01, 1,1, 0,0));
      tbl.push_back(mk(1, 1,1, 1,1, 1, 2'b01, 1,1, 1,0));
      tbl.push_back(mk(1, 0,0, 1,1, 0, 2'b01, 0,0, 0,0));
      tbl.push_back(mk(1, 0,0, 1,1, 0, 2'b00, 0,0, 0,0));
      tbl.push_back(mk(1, 0,0, 1,1, 0, 2'b10, 1,1, 0,0));
      tbl.push_back(mk(1, 0,0, 1,1, 1, 2'b10, 1,1, 0,1));
      // m1 keeps cyc, stb toggles, m0 requests throughout: stays locked
      tbl.push_back(mk(1, 1,1, 1,0, 0, 2'b10, 1,0, 0,0));
      tbl.push_back(mk(1, 1,1, 1,1, 1, 2'b10, 1,1, 0,1));
      tbl.push_back(mk(1, 1,1, 1,0, 0, 2'b10, 1,0, 0,0));
      tbl.push_back(mk(1, 1,1, 1,1, 1, 2'b10, 1,1, 0,1));
      tbl.push_back(mk(1, 1,1, 0,0, 0, 2'b10, 0,0, 0,0));
      tbl.push_back(mk(1, 1,1, 0,0, 0, 2'b00, 0,0, 0,0));
      tbl.push_back(mk(1, 1,1, 0,0, 0, 2'b01, 1,1, 0,0));
      // late acks around release are not forwarded
      tbl.push_back(mk(1, 0,0, 0,0, 1, 2'b01, 0,0, 0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 1, 2'b00, 0,0, 0,0));
      // reset in the middle of an m1 transfer
      tbl.push_back(mk(1, 0,0, 1,1, 0, 2'b00, 0,0, 0,0));
      tbl.push_back(mk(0, 0,0, 1,1, 0, 2'b10, 1,1, 0,0));
      tbl.push_back(mk(1, 0,0, 1,1, 1, 2'b00, 0,0, 0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 0, 2'b10, 0,0, 0,0));
      tbl.push_back(mk(1, 0,0, 0,0, 0, 2'b00, 0,0, 0,0));
   end

   // ---------------- stimulus ----------------
   initial begin
      rstn = 1'b0;
      idle_inputs();
      for (int m = 0; m < 2; m++) begin
         sel[m] = 4'hF; adr[m] = 32'h0; wdat[m] = 32'h0;
      end
      adr[0]  = 32'h0000_0010;
      adr[1]  = 32'h0000_0020;
      wdat[1] = 32'h1234_5678;
      we[1]   = 1'b1;
      s_dat   = 32'hDEAD_BEEF;
      step();                                // first reset edge

      foreach (tbl[i]) begin
         rstn  = tbl[i].rst_n;
         cyc   = {tbl[i].c1, tbl[i].c0};
         stb   = {tbl[i].s1, tbl[i].s0};
         s_ack = tbl[i].sack;
         #4;
         chk($sformatf("tbl[%0d] grant", i), grant, tbl[i].g);
         chk($sformatf("tbl[%0d] s_cyc", i), s_cyc, tbl[i].scyc);
         chk($sformatf("tbl[%0d] s_stb", i), s_stb, tbl[i].sstb);
         chk($sformatf("tbl[%0d] m0_ack", i), ack[0], tbl[i].a0);
         chk($sformatf("tbl[%0d] m1_ack", i), ack[1], tbl[i].a1);
         chk($sformatf("tbl[%0d] err", i), err, 2'b00);
         step();
      end

      // single read from m0, slave answers two cycles after the strobe
      rstn = 1'b1;
      idle_inputs();
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; s_dat = 32'h0;
      #4 chk("rd arb cycle grant", grant, 2'b00);
      step();
      #4;
      chk("rd grant", grant, 2'b01);
      chk("rd s_stb", s_stb, 1'b1);
      chk("rd s_adr", s_adr, 32'h0000_0010);
      chk("rd s_we", s_we, 1'b0);
      chk("rd early m0_ack", ack[0], 1'b0);
      step();
      #4 chk("rd wait m0_ack", ack[0], 1'b0);
      step();
      s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
      #4;
      chk("rd m0_ack", ack[0], 1'b1);
      chk("rd m0_dat", rdat[0], 32'hDEAD_BEEF);
      chk("rd m1_ack", ack[1], 1'b0);
      chk("rd m1_dat", rdat[1], 32'h0);
      step();
      idle_inputs();
      step();

      // m1 write appears unchanged on the slave port
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
      #4 chk("wr arb cycle grant", grant, 2'b00);
      step();
      s_ack = 1'b1;
      #4;
      chk("wr grant", grant, 2'b10);
      chk("wr s_we", s_we, 1'b1);
      chk("wr s_adr", s_adr, 32'h0000_0020);
      chk("wr s_dat", s_wdat, 32'h1234_5678);
      chk("wr s_sel", s_sel, 4'hF);
      chk("wr m1_ack", ack[1], 1'b1);
      chk("wr m0_ack", ack[0], 1'b0);
      step();
      idle_inputs();
      step();

      // slave never answers an m0 strobe
      cyc[0] = 1'b1; stb[0] = 1'b1;
      step();
`ifdef WB_ARB_TIMEOUT_EN
      for (int k = 0; k < TO; k++) begin
         #4;
         chk($sformatf("tmo err k=%0d", k), err[0], k == TO - 1);
         chk($sformatf("tmo s_cyc k=%0d", k), s_cyc, k != TO - 1);
         step();
      end
      #4 chk("tmo release grant", grant, 2'b00);
      step();
      #4 chk("tmo regrant", grant, 2'b01);
`else
      for (int k = 0; k < 300; k++) begin
         #4;
         chk("hung grant", grant, 2'b01);
         chk("hung err", err, 2'b00);
         step();
      end
`endif
      idle_inputs();
      step();
      step();

      // random traffic against the model, starting from a reset
      rstn = 1'b0;
      step();
      for (int n = 0; n < 3000; n++) begin
         rstn = ($urandom_range(0, 149) != 0);
         for (int m = 0; m < 2; m++) begin
            if (cyc[m]) cyc[m] = ($urandom_range(0, 5) != 0);
            else        cyc[m] = ($urandom_range(0, 2) == 0);
            stb[m]  = cyc[m] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            we[m]   = 1'($urandom);
            sel[m]  = 4'($urandom);
            adr[m]  = $urandom;
            wdat[m] = $urandom;
         end
         s_ack = ($urandom_range(0, 9) < 4);
         s_dat = $urandom;
         #4 mdl_check();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
